// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg -- shared definitions for the handshake pipe FIFO.
//
// Contents:
//   HS_DATA_W    default payload width of the master data bus
//   HS_STAT_W    width of the optional statistics counters
//   fifo_state_e occupancy state of the buffer (EMPTY / PARTIAL / FULL)
// ---------------------------------------------------------------------------
package hs_pkg;

    localparam int HS_DATA_W = 3;
    localparam int HS_STAT_W = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_e;

endpackage : hs_pkg

// File: rtl/hs_fifo_mem.sv
// ---------------------------------------------------------------------------
// hs_fifo_mem -- DEPTH x DATA_W register array, one synchronous write port
// and one asynchronous read port. Contents are intentionally not reset:
// a word is only ever read after it has been written.
//
// Ports:
//   clk    in   1       write clock (rising edge)
//   we     in   1       write enable
//   waddr  in   PTR_W   write address
//   wdata  in   DATA_W  write data
//   raddr  in   PTR_W   read address
//   rdata  out  DATA_W  read data (combinational from the array)
// ---------------------------------------------------------------------------
module hs_fifo_mem #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : hs_fifo_mem

// File: rtl/hs_pipe_fifo.sv
// ---------------------------------------------------------------------------
// hs_pipe_fifo -- elastic valid/ready buffer between a producer (s_*) and a
// consumer (m_*). Holds up to DEPTH words in order. Both s_ready and m_valid
// are decoded from the registered occupancy state, so neither handshake has a
// combinational path from the opposite side.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid may not depend on ready, and a raised valid (with its data) is
// held until the transfer.
//
// Ports:
//   sys_clk    in   1       clock, rising edge
//   sys_rst_n  in   1       asynchronous active-low reset
//   s_valid    in   1       producer word valid
//   s_data     in   DATA_W  producer word
//   s_ready    out  1       buffer can take a word this cycle
//   m_valid    out  1       head word valid
//   m_data     out  DATA_W  head word (0 while empty)
//   m_ready    in   1       consumer takes the head word this cycle
//   level      out  CNT_W   occupancy 0..DEPTH
//   stall_cnt  out  16      cycles with m_valid & !m_ready   (HS_FIFO_STATS_EN)
//   xfer_cnt   out  16      words popped                      (HS_FIFO_STATS_EN)
//
// Build option: define HS_FIFO_STATS_EN to add the saturating statistics
// counters and their ports.
// ---------------------------------------------------------------------------
module hs_pipe_fifo
    import hs_pkg::*;
#(
    parameter  int DATA_W = HS_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 s_valid,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [DATA_W-1:0]    m_data,
    input  logic                 m_ready,
`ifdef HS_FIFO_STATS_EN
    output logic [HS_STAT_W-1:0] stall_cnt,
    output logic [HS_STAT_W-1:0] xfer_cnt,
`endif
    output logic [CNT_W-1:0]     level
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_state_e       state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] mem_rdata;
    logic              push;
    logic              pop;

    // Handshake outputs come only from the registered state.
    assign s_ready = (state_q != FULL);
    assign m_valid = (state_q != EMPTY);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign level   = level_q;

    // Storage contents are stale after reset, so force zero while empty.
    assign m_data  = (level_q == '0) ? '0 : mem_rdata;

    hs_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (sys_clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (s_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Next-state logic. The state always matches level_d; it is kept as its
    // own register so the handshake outputs decode from two flops.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop && (level_q == CNT_W'(DEPTH - 1))) begin
                    state_d = FULL;
                end else if (pop && !push && (level_q == CNT_W'(1))) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // push is impossible here because s_ready is low.
                if (pop) begin
                    state_d = PARTIAL;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef HS_FIFO_STATS_EN
    logic [HS_STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [HS_STAT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + HS_STAT_W'(1);
        end
        if (pop && (xfer_cnt_q != '1)) begin
            xfer_cnt_d = xfer_cnt_q + HS_STAT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign xfer_cnt  = xfer_cnt_q;
`endif

endmodule : hs_pipe_fifo

// File: tb/tb_hs_pipe_fifo.sv
// ---------------------------------------------------------------------------
// tb_hs_pipe_fifo -- self-checking bench for hs_pipe_fifo.
// The reference is a plain queue of words: ready while fewer than DEPTH
// words are held, valid while any are held, head word on m_data.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hs_pipe_fifo;

    localparam int DATA_W = 3;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic [CNT_W-1:0]  level;
`ifdef HS_FIFO_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       xfer_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DATA_W-1:0] exp_q[$];
    int                exp_stall = 0;
    int                exp_xfer  = 0;

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    hs_pipe_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
`ifdef HS_FIFO_STATS_EN
        .stall_cnt (stall_cnt),
        .xfer_cnt  (xfer_cnt),
`endif
        .level     (level)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Compare every DUT output against the queue model.
    task automatic compare_model();
        int          n;
        logic [31:0] head;
        n    = exp_q.size();
        head = (n > 0) ? 32'(exp_q[0]) : 32'd0;
        check("m_valid", 32'(m_valid), (n > 0) ? 32'd1 : 32'd0);
        check("s_ready", 32'(s_ready), (n < DEPTH) ? 32'd1 : 32'd0);
        check("level",   32'(level),   32'(n));
        check("m_data",  32'(m_data),  head);
`ifdef HS_FIFO_STATS_EN
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        check("xfer_cnt",  32'(xfer_cnt),  32'(exp_xfer));
`endif
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: check, drive, advance the model over the
    // coming rising edge, then wait for the next falling edge.
    task automatic cycle(input logic sv, input logic [DATA_W-1:0] sd, input logic mr);
        bit push;
        bit pop;
        compare_model();
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        push = sv && (exp_q.size() < DEPTH);
        pop  = mr && (exp_q.size() > 0);
        if ((exp_q.size() > 0) && !mr && (exp_stall < 16'hFFFF)) exp_stall++;
        if (pop && (exp_xfer < 16'hFFFF)) exp_xfer++;
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(sd);
        @(negedge sys_clk);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        sys_rst_n = 1'b0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_level",   32'(level),   32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_data",  32'(m_data),  32'd0);
`ifdef HS_FIFO_STATS_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
`endif
        exp_q.delete();
        exp_stall = 0;
        exp_xfer  = 0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] t3_exp [8];
        logic              hold_v;
        logic [DATA_W-1:0] hold_d;
        int                p_valid;
        int                p_ready;

        t3_exp = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

        sys_rst_n = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("init_m_valid", 32'(m_valid), 32'd0);
        check("init_s_ready", 32'(s_ready), 32'd1);
        check("init_level",   32'(level),   32'd0);
        check("init_m_data",  32'(m_data),  32'd0);
        sys_rst_n = 1'b1;

        // 1: four pushes with the consumer stalled.
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, DATA_W'(k), 1'b0);
            check("t1_m_data_head", 32'(m_data), 32'd1);
            check("t1_s_ready", 32'(s_ready), (k < 4) ? 32'd1 : 32'd0);
        end
        check("t1_level", 32'(level), 32'd4);

        // 2: drain in order.
        for (int k = 1; k <= 4; k++) begin
            check("t2_pop_data", 32'(m_data), 32'(k));
            cycle(1'b0, '0, 1'b1);
        end
        check("t2_m_valid", 32'(m_valid), 32'd0);
        check("t2_level",   32'(level),   32'd0);

        // 3: stream through at level 2.
        cycle(1'b1, 3'd6, 1'b0);
        cycle(1'b1, 3'd7, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("t3_pop_data", 32'(m_data), 32'(t3_exp[i]));
            cycle(1'b1, DATA_W'(i), 1'b1);
        end
        check("t3_level", 32'(level), 32'd2);

        // 4: push offered while full with a same-cycle pop.
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int k = 1; k <= 4; k++) cycle(1'b1, DATA_W'(k), 1'b0);
        check("t4_full_s_ready", 32'(s_ready), 32'd0);
        cycle(1'b1, 3'd7, 1'b1);
        check("t4_level_after_pop", 32'(level), 32'd3);
        check("t4_s_ready", 32'(s_ready), 32'd1);
        check("t4_head", 32'(m_data), 32'd2);
        cycle(1'b1, 3'd7, 1'b0);
        check("t4_level_after_push", 32'(level), 32'd4);

        // 5: reset mid-burst at level 3.
        cycle(1'b0, '0, 1'b1);
        check("t5_level_pre", 32'(level), 32'd3);
        do_reset();
        cycle(1'b1, 3'd5, 1'b0);
        check("t5_post_push", 32'(m_data), 32'd5);
        cycle(1'b0, '0, 1'b1);
        check("t5_drained", 32'(level), 32'd0);

`ifdef HS_FIFO_STATS_EN
        // 6: statistics counters.
        do_reset();
        cycle(1'b1, 3'd1, 1'b0);
        cycle(1'b1, 3'd2, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t6_stall_cnt", 32'(stall_cnt), 32'd3);
        check("t6_xfer_cnt",  32'(xfer_cnt),  32'd2);
`endif

        // Random interleavings; the producer holds a refused word stable.
        hold_v  = 1'b0;
        hold_d  = '0;
        p_valid = 50;
        p_ready = 50;
        for (int n = 0; n < 3000; n++) begin
            logic              sv;
            logic [DATA_W-1:0] sd;
            logic              mr;
            if ((n % 200) == 0) begin
                p_valid = $urandom_range(10, 95);
                p_ready = $urandom_range(10, 95);
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                hold_v = 1'b0;
            end
            if (hold_v) begin
                sv = 1'b1;
                sd = hold_d;
            end else begin
                sv = ($urandom_range(0, 99) < p_valid);
                sd = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            end
            mr     = ($urandom_range(0, 99) < p_ready);
            hold_v = sv && (exp_q.size() >= DEPTH);
            hold_d = sd;
            cycle(sv, sd, mr);
        end
        compare_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hs_pipe_fifo
